// File: rtl/ex_muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// ex_muldiv_unit_pkg : shared FUNCT3 codes, FSM states and decode helpers
// Rev 1.0
// ============================================================================
package ex_muldiv_unit_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic f3_signed_div(input logic [2:0] f3);
    return (f3 == MD_DIV) || (f3 == MD_REM);
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return (f3 == MD_REM) || (f3 == MD_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// ex_muldiv_unit_if : request/result bundle between ID/EX and the muldiv unit
// Rev 1.0
// ============================================================================
interface ex_muldiv_unit_if;

  logic        start;
  logic [2:0]  funct3;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  modport master (
    output start, funct3, operand1, operand2, rd_in, flush,
    input  busy, result_valid, result, rd_out
  );

  modport slave (
    input  start, funct3, operand1, operand2, rd_in, flush,
    output busy, result_valid, result, rd_out
  );

endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit_divider.sv
`default_nettype none
// ============================================================================
// ex_muldiv_unit_divider : magnitude-only restoring divider, one bit per step
// Rev 1.0
// ============================================================================
module ex_muldiv_unit_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [5:0]       count_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [5:0]       cnt_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  // Outputs show the values after the step taken at the coming edge.
  assign shifted     = {rem_q, quo_q[WIDTH-1]};
  assign diff        = shifted - {1'b0, dvs_q};
  assign fits        = ~diff[WIDTH];
  assign quotient_o  = {quo_q[WIDTH-2:0], fits};
  assign remainder_o = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign count_o     = cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
      cnt_q <= '0;
    end else if (step_i) begin
      quo_q <= quotient_o;
      rem_q <= remainder_o;
      cnt_q <= cnt_q + 6'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// ex_muldiv_unit : RV32M multiply/divide unit for the EX stage
// Rev 1.0
// ============================================================================
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ex_muldiv_unit_if.slave bus
);

  localparam logic [1:0]      MUL_LAST = 2'(MUL_CYCLES - 2);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [XLEN-1:0]   op1_q, op2_q;
  logic [2:0]        f3_q;
  logic [4:0]        rd_q;
  logic [1:0]        mcnt_q, mcnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              valid_q, valid_d;
  logic              busy, accept, div_step;

  logic [XLEN-1:0]   dvd_mag, dvs_mag, div_quo, div_rem, div_res, spec_res;
  logic [5:0]        div_cnt;
  logic              in_signed, sgn, div_zero, div_ovf, special, q_neg, r_neg;

  logic signed [XLEN:0]     mul_a, mul_b;
  logic signed [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0]        mul_src;

  assign busy = (state_q != S_IDLE);

  assign in_signed = f3_signed_div(bus.funct3);
  assign dvd_mag   = (in_signed && bus.operand1[XLEN-1]) ? -bus.operand1 : bus.operand1;
  assign dvs_mag   = (in_signed && bus.operand2[XLEN-1]) ? -bus.operand2 : bus.operand2;

  ex_muldiv_unit_divider #(.WIDTH(XLEN)) u_divider (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (accept && bus.funct3[2]),
    .step_i      (div_step),
    .dividend_i  (dvd_mag),
    .divisor_i   (dvs_mag),
    .count_o     (div_cnt),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  assign sgn      = f3_signed_div(f3_q);
  assign div_zero = (op2_q == '0);
  assign div_ovf  = sgn && (op1_q == MIN_NEG) && (op2_q == '1);
  assign special  = div_zero || div_ovf;
  assign q_neg    = sgn && (op1_q[XLEN-1] ^ op2_q[XLEN-1]);
  assign r_neg    = sgn && op1_q[XLEN-1];
  assign div_res  = f3_is_rem(f3_q) ? (r_neg ? -div_rem : div_rem)
                                    : (q_neg ? -div_quo : div_quo);
  assign spec_res = div_zero ? (f3_is_rem(f3_q) ? op1_q : '1)
                             : (f3_is_rem(f3_q) ? '0 : MIN_NEG);

  // Extension bit selects signed/unsigned per operand; product is the low 2*XLEN bits.
  assign mul_a = {(f3_q != MD_MULHU) && op1_q[XLEN-1], op1_q};
  assign mul_b = {((f3_q == MD_MUL) || (f3_q == MD_MULH)) && op2_q[XLEN-1], op2_q};
  assign prod  = (2*XLEN)'(mul_a) * (2*XLEN)'(mul_b);

  if (MUL_CYCLES == 3) begin : g_mul_pipe
    logic [2*XLEN-1:0] prod_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) prod_q <= '0;
      else       prod_q <= prod;
    end
    assign mul_src = prod_q;
  end else begin : g_mul_direct
    assign mul_src = prod;
  end

  always_comb begin
    state_d  = state_q;
    mcnt_d   = mcnt_q;
    result_d = result_q;
    rd_out_d = rd_out_q;
    valid_d  = 1'b0;
    accept   = 1'b0;
    div_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          accept  = 1'b1;
          mcnt_d  = 2'd0;
          state_d = bus.funct3[2] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        if (mcnt_q == MUL_LAST) begin
          state_d  = S_DONE;
          result_d = (f3_q == MD_MUL) ? mul_src[XLEN-1:0] : mul_src[2*XLEN-1:XLEN];
          rd_out_d = rd_q;
        end else begin
          mcnt_d = mcnt_q + 2'd1;
        end
      end
      S_DIV: begin
        // Special cases spend one cycle here for operand decode, then skip iteration.
        if (special) begin
          state_d  = S_DONE;
          result_d = spec_res;
          rd_out_d = rd_q;
        end else begin
          div_step = 1'b1;
          if (div_cnt == 6'd31) begin
            state_d  = S_DONE;
            result_d = div_res;
            rd_out_d = rd_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        valid_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (busy && bus.flush) begin
      state_d  = S_IDLE;
      valid_d  = 1'b0;
      div_step = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mcnt_q   <= '0;
      result_q <= '0;
      rd_out_q <= '0;
      valid_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
      valid_q  <= valid_d;
      if (accept) begin
        op1_q <= bus.operand1;
        op2_q <= bus.operand2;
        f3_q  <= bus.funct3;
        rd_q  <= bus.rd_in;
      end
    end
  end

  assign bus.busy         = busy;
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;
  assign bus.rd_out       = rd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_ex_muldiv_unit : scoreboard bench for the RV32M multiply/divide unit
// Rev 1.0
// ============================================================================
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_muldiv_unit_if bus();

  ex_muldiv_unit #(.XLEN(32), .MUL_CYCLES(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t scb[$];
  int   edge_n  = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic int lat_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3 < 3'd4) return 2;
    if (b == 32'd0) return 2;
    if (((f3 == MD_DIV) || (f3 == MD_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))
      return 2;
    return 33;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    r   = '0;
    case (f3)
      MD_MUL:    begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      MD_MULH:   begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
      MD_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
      MD_MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      MD_DIV: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (ovf)   r = 32'h8000_0000;
        else            r = $signed(a) / $signed(b);
      end
      MD_DIVU: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else            r = a / b;
      end
      MD_REM: begin
        if (b == 32'd0) r = a;
        else if (ovf)   r = 32'd0;
        else            r = $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) r = a;
        else            r = a % b;
      end
    endcase
    return r;
  endfunction

  // Result monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.result_valid === 1'b1) begin
      n_tests++;
      if (scb.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_valid: result=%h rd=%0d at edge %0d, required no pulse",
                 bus.result, bus.rd_out, edge_n);
      end else begin
        e = scb.pop_front();
        if (bus.result !== e.res || bus.rd_out !== e.rd || edge_n != e.due) begin
          n_fail++;
          $display("FAIL result: got %h rd=%0d edge=%0d, required %h rd=%0d edge=%0d",
                   bus.result, bus.rd_out, edge_n, e.res, e.rd, e.due);
        end
      end
    end
  end

  // Called at a negedge; holds START until the unit is idle, then records the expectation.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res);
    int waited;
    int lat;
    lat          = lat_of(f3, a, b);
    bus.start    = 1'b1;
    bus.funct3   = f3;
    bus.operand1 = a;
    bus.operand2 = b;
    bus.rd_in    = rd;
    waited       = 0;
    while (bus.busy !== 1'b0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (waited >= 100) begin
      n_fail++;
      $display("FAIL issue_timeout: busy=%b, required 0 within 100 cycles", bus.busy);
    end else begin
      scb.push_back('{res: exp_res, rd: rd, due: edge_n + 1 + lat});
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int w;
    w = 0;
    bus.start = 1'b0;
    while (scb.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    n_tests++;
    if (scb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", scb.size());
      scb.delete();
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    n_tests += 4;
    if (bus.busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy); end
    if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", bus.result_valid); end
    if (bus.result !== 32'd0)      begin n_fail++; $display("FAIL reset_result: got %h, required 0", bus.result); end
    if (bus.rd_out !== 5'd0)       begin n_fail++; $display("FAIL reset_rd: got %0d, required 0", bus.rd_out); end
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int nb;
    issue(MD_MUL, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB);
    bus.start = 1'b0;
    nb = 0;
    while (bus.busy === 1'b1 && nb < 10) begin
      nb++;
      @(negedge clk);
    end
    n_tests++;
    if (nb != 2) begin
      n_fail++;
      $display("FAIL mul_busy_cycles: got %0d, required 2", nb);
    end
    drain();
  endtask

  task automatic test_mulh();
    issue(MD_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000);
    issue(MD_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000);
    issue(MD_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h7FFF_FFFF);
    drain();
  endtask

  task automatic test_div();
    issue(MD_DIV,  32'hFFFF_FFF9, 32'd2,  5'd5, 32'hFFFF_FFFD);
    issue(MD_REM,  32'hFFFF_FFF9, 32'd2,  5'd6, 32'hFFFF_FFFF);
    issue(MD_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd7, 32'h0FFF_FFFF);
    drain();
  endtask

  task automatic test_special();
    issue(MD_DIVU, 32'd5,          32'd0,         5'd8,  32'hFFFF_FFFF);
    issue(MD_REM,  32'd5,          32'd0,         5'd9,  32'd5);
    issue(MD_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 32'h8000_0000);
    issue(MD_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'd0);
    issue(MD_DIV,  32'hFFFF_FFFB,  32'd0,         5'd12, 32'hFFFF_FFFF);
    issue(MD_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 32'h8000_0000);
    drain();
  endtask

  task automatic test_flush();
    int e0;
    issue(MD_DIV, 32'd100, 32'd7, 5'd14, 32'd14);
    bus.start = 1'b0;
    e0 = edge_n;
    while (edge_n < e0 + 9) @(negedge clk);
    void'(scb.pop_back());
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy: got %b, required 0", bus.busy);
    end
    issue(MD_MUL, 32'd12, 32'd11, 5'd15, 32'd132);
    drain();
  endtask

  task automatic test_flush_done();
    issue(MD_MUL, 32'd3, 32'd4, 5'd16, 32'd12);
    bus.start = 1'b0;
    @(negedge clk);
    void'(scb.pop_back());
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_tests += 2;
    if (bus.busy !== 1'b0)         begin n_fail++; $display("FAIL flush_done_busy: got %b, required 0", bus.busy); end
    if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL flush_done_valid: got %b, required 0", bus.result_valid); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_start_flush_idle();
    bus.start  = 1'b1;
    bus.funct3 = MD_MUL;
    bus.flush  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_flush_idle: busy=%b, required 0", bus.busy);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    issue(MD_MUL, 32'd6,          32'd7,          5'd17, 32'd42);
    issue(MD_MUL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd18, 32'd1);
    issue(MD_MUL, 32'h0001_0000,  32'h0001_0000,  5'd19, 32'd0);
    drain();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    for (int i = 0; i < 12; i++) begin
      a  = $urandom;
      b  = (i % 5 == 4) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      f3 = 3'(i % 8);
      issue(f3, a, b, 5'(20 + i), model(f3, a, b));
    end
    drain();
  endtask

  task automatic test_reset_mid();
    issue(MD_DIV, 32'd1000, 32'd3, 5'd31, 32'd333);
    bus.start = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    scb.delete();
    n_tests += 4;
    if (bus.busy !== 1'b0)         begin n_fail++; $display("FAIL mid_reset_busy: got %b, required 0", bus.busy); end
    if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b, required 0", bus.result_valid); end
    if (bus.result !== 32'd0)      begin n_fail++; $display("FAIL mid_reset_result: got %h, required 0", bus.result); end
    if (bus.rd_out !== 5'd0)       begin n_fail++; $display("FAIL mid_reset_rd: got %0d, required 0", bus.rd_out); end
    repeat (40) @(negedge clk);
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: busy=%b, required 0", bus.busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start    = 1'b0;
    bus.funct3   = 3'd0;
    bus.operand1 = 32'd0;
    bus.operand2 = 32'd0;
    bus.rd_in    = 5'd0;
    bus.flush    = 1'b0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_flush_done();
    test_start_flush_idle();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
